hs_ram_port: RTL



---
 rtl/hs_ram_port.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hs_ram_port.sv
`default_nettype none
// ============================================================================
// hs_ram_port : hands the work-RAM port between the game CPU and the hiscore
//               engine. Optional macro: HS_RAM_WRITE_GUARD_EN (sticky flag).
// Revision    : 1.0 - initial release
// ============================================================================
module hs_ram_port #(
    parameter int AW    = 11,
    parameter int DW    = 8,
    parameter int GUARD = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          paused,
    input  logic [AW-1:0] hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write_enable,
    input  logic          hs_read_intent,
    input  logic          hs_write_intent,
    output logic [DW-1:0] hs_data_out,
    output logic          hs_owned,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_dout,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic          hs_violation
);

    typedef enum logic [1:0] {
        ST_CPU   = 2'd0,
        ST_GRANT = 2'd1,
        ST_HS    = 2'd2
    } state_t;

    localparam logic [1:0] c_guard_load = 2'(GUARD);

    state_t        state_q, state_d;
    logic [1:0]    guard_cnt_q, guard_cnt_d;
    logic          was_cpu_q, was_cpu_d;
    logic          was_hs_q, was_hs_d;
    logic          hs_owned_q, hs_owned_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;
    logic [DW-1:0] hs_data_out_q, hs_data_out_d;
    logic          w_intent;

    assign w_intent = hs_read_intent | hs_write_intent;

    always_comb begin
        state_d       = state_q;
        guard_cnt_d   = guard_cnt_q;
        ram_addr      = cpu_addr;
        ram_din       = cpu_din;
        ram_we        = cpu_we;
        unique case (state_q)
            ST_CPU: begin
                if (paused && w_intent) begin
                    state_d     = ST_GRANT;
                    guard_cnt_d = c_guard_load;
                end
            end
            ST_GRANT: begin
                ram_addr = hs_address;
                ram_din  = hs_data_in;
                ram_we   = 1'b0;
                if (!paused || !w_intent) begin
                    state_d = ST_CPU;
                end else if (guard_cnt_q <= 2'd1) begin
                    state_d = ST_HS;
                end else begin
                    guard_cnt_d = guard_cnt_q - 2'd1;
                end
            end
            ST_HS: begin
                ram_addr = hs_address;
                ram_din  = hs_data_in;
                // A write arriving with reset asserted is discarded.
                ram_we   = hs_write_enable & reset_n;
                if (!paused || !w_intent) begin
                    state_d = ST_CPU;
                end
            end
            default: state_d = ST_CPU;
        endcase
        was_cpu_d     = (state_q == ST_CPU);
        was_hs_d      = (state_q == ST_GRANT) || (state_q == ST_HS);
        hs_owned_d    = (state_d == ST_HS);
        cpu_dout_d    = was_cpu_q ? ram_dout : cpu_dout_q;
        hs_data_out_d = was_hs_q  ? ram_dout : hs_data_out_q;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q       <= ST_CPU;
            guard_cnt_q   <= c_guard_load;
            was_cpu_q     <= 1'b0;
            was_hs_q      <= 1'b0;
            hs_owned_q    <= 1'b0;
            cpu_dout_q    <= '0;
            hs_data_out_q <= '0;
        end else begin
            state_q       <= state_d;
            guard_cnt_q   <= guard_cnt_d;
            was_cpu_q     <= was_cpu_d;
            was_hs_q      <= was_hs_d;
            hs_owned_q    <= hs_owned_d;
            cpu_dout_q    <= cpu_dout_d;
            hs_data_out_q <= hs_data_out_d;
        end
    end

    assign hs_owned    = hs_owned_q;
    assign cpu_dout    = cpu_dout_q;
    assign hs_data_out = hs_data_out_q;

`ifdef HS_RAM_WRITE_GUARD_EN
    logic hs_violation_q, hs_violation_d;

    always_comb begin
        hs_violation_d = hs_violation_q
                       | (hs_write_enable && (state_q != ST_HS))
                       | (cpu_we && (state_q != ST_CPU));
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hs_violation_q <= 1'b0;
        end else begin
            hs_violation_q <= hs_violation_d;
        end
    end

    assign hs_violation = hs_violation_q;
`else
    assign hs_violation = 1'b0;
`endif

endmodule
`default_nettype wire
